// File: rtl/power_seq_pkg.sv
// Shared types and helpers for the multi-rail power sequencer.
package power_seq_pkg;

  localparam int unsigned STAGE_IDX_W = 3;
  localparam int unsigned MAX_RAILS   = 16;
  localparam int unsigned MAP_W       = STAGE_IDX_W * MAX_RAILS;
  localparam int unsigned STATE_W     = 3;
  localparam int unsigned RETRY_W     = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_RAMP     = 3'd1,
    ST_RUN      = 3'd2,
    ST_SHUTDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } seq_state_e;

  // Stage index of a rail from the packed per-rail stage map.
  function automatic logic [STAGE_IDX_W-1:0] stage_of_rail(input logic [MAP_W-1:0] map,
                                                           input int unsigned rail);
    logic [MAP_W-1:0] shifted;
    shifted = map >> (STAGE_IDX_W * rail);
    return shifted[STAGE_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rail_fault_filter.sv
// Per-rail voltage/current bad-time filters with sticky fault flags and rail-good status.
module rail_fault_filter #(
  parameter int unsigned CNT_WIDTH   = 24,
  parameter int unsigned ERROR_DELAY = 8320000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_mon_en,
  input  logic i_mon_next,
  input  logic i_chk,
  input  logic i_clear,
  input  logic i_voltage_good,
  input  logic i_current_good,
  output logic o_voltage_fault,
  output logic o_current_fault,
  output logic o_rail_good,
  output logic o_fault_c
);

  localparam logic [CNT_WIDTH-1:0] ERR_LAST = CNT_WIDTH'(ERROR_DELAY - 1);

  logic [CNT_WIDTH-1:0] v_cnt_q, v_cnt_d, c_cnt_q, c_cnt_d;
  logic v_fault_q, v_fault_d, c_fault_q, c_fault_d;
  logic rail_good_q, rail_good_d;
  logic v_bad_c, c_bad_c, v_set_c, c_set_c;

  // A fault sets on the last allowed bad cycle or on a failed startup check.
  assign v_bad_c   = i_mon_en & ~i_voltage_good;
  assign c_bad_c   = i_mon_en & ~i_current_good;
  assign v_set_c   = (v_bad_c & (v_cnt_q == ERR_LAST)) | (i_chk & ~i_voltage_good);
  assign c_set_c   = (c_bad_c & (c_cnt_q == ERR_LAST)) | (i_chk & ~i_current_good);
  assign o_fault_c = v_set_c | c_set_c;

  always_comb begin
    v_cnt_d = '0;
    c_cnt_d = '0;
    if (v_bad_c) v_cnt_d = (v_cnt_q == ERR_LAST) ? v_cnt_q : v_cnt_q + CNT_WIDTH'(1);
    if (c_bad_c) c_cnt_d = (c_cnt_q == ERR_LAST) ? c_cnt_q : c_cnt_q + CNT_WIDTH'(1);
    // A new fault takes priority over a same-cycle clear.
    v_fault_d   = v_set_c | (v_fault_q & ~i_clear);
    c_fault_d   = c_set_c | (c_fault_q & ~i_clear);
    rail_good_d = i_mon_next & i_voltage_good & i_current_good & ~v_fault_d & ~c_fault_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v_cnt_q     <= '0;
      c_cnt_q     <= '0;
      v_fault_q   <= 1'b0;
      c_fault_q   <= 1'b0;
      rail_good_q <= 1'b0;
    end else begin
      v_cnt_q     <= v_cnt_d;
      c_cnt_q     <= c_cnt_d;
      v_fault_q   <= v_fault_d;
      c_fault_q   <= c_fault_d;
      rail_good_q <= rail_good_d;
    end
  end

  assign o_voltage_fault = v_fault_q;
  assign o_current_fault = c_fault_q;
  assign o_rail_good     = rail_good_q;

endmodule

// File: rtl/power_sequencer.sv
// Multi-rail, multi-stage power sequencer: ordered ramp, monitored run, reverse shutdown.
// Optional auto-retry out of FAULT is enabled by defining PWRSEQ_AUTO_RETRY_EN.
module power_sequencer
  import power_seq_pkg::*;
#(
  parameter int unsigned NUM_RAILS      = 4,
  parameter int unsigned NUM_STAGES     = 3,
  parameter logic [STAGE_IDX_W*NUM_RAILS-1:0] STAGE_MAP = 12'h448,
  parameter int unsigned STARTUP_DELAY  = 4160000,
  parameter int unsigned ERROR_DELAY    = 8320000,
  parameter int unsigned SHUTDOWN_DELAY = 416000,
  parameter int unsigned RETRY_DELAY    = 4160000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_WIDTH      = 24
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_clearFaults,
  input  logic [NUM_RAILS-1:0]  i_voltageGood,
  input  logic [NUM_RAILS-1:0]  i_currentGood,
  output logic [NUM_STAGES-1:0] o_stageEnable,
  output logic [NUM_STAGES-1:0] o_stageGood,
  output logic [NUM_RAILS-1:0]  o_railGood,
  output logic [NUM_RAILS-1:0]  o_voltageFault,
  output logic [NUM_RAILS-1:0]  o_currentFault,
  output logic                  o_faultLatched,
  output logic [STATE_W-1:0]    o_state,
  output logic [RETRY_W-1:0]    o_retryCount
);

`ifdef PWRSEQ_AUTO_RETRY_EN
  localparam bit AUTO_RETRY = 1'b1;
`else
  localparam bit AUTO_RETRY = 1'b0;
`endif

  localparam logic [MAP_W-1:0]     MAP_EXT      = MAP_W'(STAGE_MAP);
  localparam logic [CNT_WIDTH-1:0] STARTUP_LAST = CNT_WIDTH'(STARTUP_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] SD_LAST      = CNT_WIDTH'(SHUTDOWN_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RETRY_LAST   = CNT_WIDTH'(RETRY_DELAY - 1);

  seq_state_e state_q, state_d;
  logic [STAGE_IDX_W-1:0] stage_q, stage_d;
  logic [CNT_WIDTH-1:0]   stg_cnt_q, stg_cnt_d;
  logic [CNT_WIDTH-1:0]   sd_cnt_q, sd_cnt_d;
  logic [NUM_STAGES-1:0]  stage_en_q, stage_en_d;
  logic [NUM_STAGES-1:0]  stage_good_q, stage_good_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic                   fault_latched_q, fault_latched_d;

  logic [NUM_RAILS-1:0]  mon_en_c, mon_next_c, chk_c, fault_c;
  logic [NUM_RAILS-1:0]  v_fault, c_fault, rail_good;
  logic [NUM_STAGES-1:0] stage_bit_c;
  logic active_c, timeout_c, last_stage_c, any_fault_c;
  logic clear_req_c, retry_go_c, filt_clear_c;

  assign active_c     = (state_q == ST_RAMP) || (state_q == ST_RUN);
  assign timeout_c    = (state_q == ST_RAMP) && (stg_cnt_q == STARTUP_LAST);
  assign last_stage_c = (stage_q == STAGE_IDX_W'(NUM_STAGES - 1));
  assign stage_bit_c  = NUM_STAGES'(1) << stage_q;
  assign any_fault_c  = |fault_c;
  assign clear_req_c  = (state_q == ST_FAULT) && i_clearFaults && !i_enable;
  assign retry_go_c   = AUTO_RETRY && (state_q == ST_FAULT) && i_enable &&
                        (sd_cnt_q == RETRY_LAST) && (retry_q < RETRY_W'(MAX_RETRIES));
  assign filt_clear_c = clear_req_c | retry_go_c;

  // Per-rail filters; rails mapped past the last stage are never monitored.
  for (genvar i = 0; i < NUM_RAILS; i++) begin : g_rail
    localparam int unsigned RS = 32'(stage_of_rail(MAP_EXT, i));
    if (RS < NUM_STAGES) begin : g_mapped
      assign mon_en_c[i]   = active_c & stage_good_q[RS];
      assign mon_next_c[i] = stage_good_d[RS];
      assign chk_c[i]      = timeout_c & (stage_q == STAGE_IDX_W'(RS));
    end else begin : g_unmapped
      assign mon_en_c[i]   = 1'b0;
      assign mon_next_c[i] = 1'b0;
      assign chk_c[i]      = 1'b0;
    end

    rail_fault_filter #(
      .CNT_WIDTH   (CNT_WIDTH),
      .ERROR_DELAY (ERROR_DELAY)
    ) u_filter (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_mon_en        (mon_en_c[i]),
      .i_mon_next      (mon_next_c[i]),
      .i_chk           (chk_c[i]),
      .i_clear         (filt_clear_c),
      .i_voltage_good  (i_voltageGood[i]),
      .i_current_good  (i_currentGood[i]),
      .o_voltage_fault (v_fault[i]),
      .o_current_fault (c_fault[i]),
      .o_rail_good     (rail_good[i]),
      .o_fault_c       (fault_c[i])
    );
  end

  assign fault_latched_d = any_fault_c | (fault_latched_q & ~filt_clear_c);

  // Enables are always a thermometer from stage 0, so a right shift drops the top one.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    stg_cnt_d    = stg_cnt_q;
    sd_cnt_d     = sd_cnt_q;
    stage_en_d   = stage_en_q;
    stage_good_d = stage_good_q;
    retry_d      = retry_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_enable && !fault_latched_q) begin
          state_d    = ST_RAMP;
          stage_d    = '0;
          stg_cnt_d  = '0;
          stage_en_d = NUM_STAGES'(1);
        end
      end
      ST_RAMP, ST_RUN: begin
        if (any_fault_c || !i_enable) begin
          state_d      = ST_SHUTDOWN;
          stage_en_d   = stage_en_q >> 1;
          stage_good_d = stage_good_q & (stage_en_q >> 1);
          sd_cnt_d     = '0;
        end else if (state_q == ST_RAMP) begin
          if (timeout_c) begin
            stage_good_d = stage_good_q | stage_bit_c;
            stg_cnt_d    = '0;
            if (last_stage_c) begin
              state_d = ST_RUN;
            end else begin
              stage_d    = stage_q + STAGE_IDX_W'(1);
              stage_en_d = stage_en_q | (stage_bit_c << 1);
            end
          end else begin
            stg_cnt_d = stg_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      ST_SHUTDOWN: begin
        if (stage_en_q == '0) begin
          state_d  = fault_latched_q ? ST_FAULT : ST_IDLE;
          stage_d  = '0;
          sd_cnt_d = '0;
        end else if (sd_cnt_q == SD_LAST) begin
          stage_en_d   = stage_en_q >> 1;
          stage_good_d = stage_good_q & (stage_en_q >> 1);
          sd_cnt_d     = '0;
        end else begin
          sd_cnt_d = sd_cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_FAULT: begin
        if (clear_req_c) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else if (retry_go_c) begin
          state_d    = ST_RAMP;
          retry_d    = retry_q + RETRY_W'(1);
          stage_d    = '0;
          stg_cnt_d  = '0;
          stage_en_d = NUM_STAGES'(1);
        end else if (sd_cnt_q != RETRY_LAST) begin
          sd_cnt_d = sd_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q         <= ST_IDLE;
      stage_q         <= '0;
      stg_cnt_q       <= '0;
      sd_cnt_q        <= '0;
      stage_en_q      <= '0;
      stage_good_q    <= '0;
      retry_q         <= '0;
      fault_latched_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stage_q         <= stage_d;
      stg_cnt_q       <= stg_cnt_d;
      sd_cnt_q        <= sd_cnt_d;
      stage_en_q      <= stage_en_d;
      stage_good_q    <= stage_good_d;
      retry_q         <= retry_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  assign o_stageEnable  = stage_en_q;
  assign o_stageGood    = stage_good_q;
  assign o_railGood     = rail_good;
  assign o_voltageFault = v_fault;
  assign o_currentFault = c_fault;
  assign o_faultLatched = fault_latched_q;
  assign o_state        = state_q;
  assign o_retryCount   = retry_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Scoreboard bench for power_sequencer with short delays (8/16/4/10) and the default rail map.
module tb_power_sequencer;

  localparam int K_EN = 0, K_GOOD = 1, K_STATE = 2, K_VF = 3;
  localparam int K_CF = 4, K_RG = 5, K_FL = 6, K_RC = 7;
  localparam logic [15:0] S_IDLE = 0, S_RAMP = 1, S_RUN = 2, S_SD = 3, S_FAULT = 4;

  typedef struct {
    int          at;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_reset, i_enable, i_clearFaults;
  logic [3:0] vg, cg;
  logic [2:0] o_stageEnable, o_stageGood, o_state;
  logic [3:0] o_railGood, o_voltageFault, o_currentFault, o_retryCount;
  logic       o_faultLatched;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  power_sequencer #(
    .NUM_RAILS(4), .NUM_STAGES(3), .STAGE_MAP(12'h448),
    .STARTUP_DELAY(8), .ERROR_DELAY(16), .SHUTDOWN_DELAY(4),
    .RETRY_DELAY(10), .MAX_RETRIES(3), .CNT_WIDTH(24)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_clearFaults(i_clearFaults),
    .i_voltageGood(vg), .i_currentGood(cg),
    .o_stageEnable(o_stageEnable), .o_stageGood(o_stageGood), .o_railGood(o_railGood),
    .o_voltageFault(o_voltageFault), .o_currentFault(o_currentFault),
    .o_faultLatched(o_faultLatched), .o_state(o_state), .o_retryCount(o_retryCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] obs(input int k);
    case (k)
      K_EN:    return 16'(o_stageEnable);
      K_GOOD:  return 16'(o_stageGood);
      K_STATE: return 16'(o_state);
      K_VF:    return 16'(o_voltageFault);
      K_CF:    return 16'(o_currentFault);
      K_RG:    return 16'(o_railGood);
      K_FL:    return 16'(o_faultLatched);
      default: return 16'(o_retryCount);
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_EN: return "stageEnable"; K_GOOD: return "stageGood"; K_STATE: return "state";
      K_VF: return "voltageFault"; K_CF: return "currentFault"; K_RG: return "railGood";
      K_FL: return "faultLatched"; default: return "retryCount";
    endcase
  endfunction

  task automatic push_exp(input int at, input int kind, input logic [15:0] val);
    exp_t e;
    e.at = at; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e; logic [15:0] got;
    i_reset = 1'b1; i_enable = 1'b0; i_clearFaults = 1'b0; vg = 4'hF; cg = 4'hF;
    repeat (3) tick();
    for (int k = 0; k < 8; k++) push_exp(cyc, k, 16'h0);
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front(); got = obs(e.kind); total++;
      if (got !== e.val) begin bad++; $display("FAIL reset %s cyc=%0d got=%0h exp=%0h", kname(e.kind), cyc, got, e.val); end
    end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_powerup();
    exp_t e; logic [15:0] got; int t0;
    t0 = cyc;
    push_exp(t0+1, K_EN, 1);   push_exp(t0+1, K_STATE, S_RAMP);
    push_exp(t0+8, K_EN, 1);   push_exp(t0+8, K_GOOD, 0);
    push_exp(t0+9, K_EN, 3);   push_exp(t0+9, K_GOOD, 1);   push_exp(t0+9, K_RG, 4'b0001);
    push_exp(t0+17, K_EN, 7);  push_exp(t0+17, K_GOOD, 3);  push_exp(t0+17, K_RG, 4'b0111);
    push_exp(t0+24, K_STATE, S_RAMP);
    push_exp(t0+25, K_STATE, S_RUN); push_exp(t0+25, K_GOOD, 7); push_exp(t0+25, K_RG, 4'hF);
    push_exp(t0+25, K_FL, 0);
    i_enable = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front(); got = obs(e.kind); total++;
        if (got !== e.val) begin bad++; $display("FAIL powerup %s cyc=%0d got=%0h exp=%0h", kname(e.kind), cyc, got, e.val); end
      end
    end
  endtask

  task automatic test_voltage_filter();
    exp_t e; logic [15:0] got; int t0;
    t0 = cyc;
    push_exp(t0+16, K_STATE, S_RUN); push_exp(t0+16, K_VF, 0);
    push_exp(t0+31, K_EN, 7);        push_exp(t0+31, K_VF, 0);
    push_exp(t0+32, K_VF, 4'b0100);  push_exp(t0+32, K_STATE, S_SD); push_exp(t0+32, K_EN, 3);
    push_exp(t0+32, K_GOOD, 3);      push_exp(t0+32, K_FL, 1);       push_exp(t0+32, K_RG, 4'b0011);
    push_exp(t0+35, K_EN, 3);        push_exp(t0+36, K_EN, 1);       push_exp(t0+39, K_EN, 1);
    push_exp(t0+40, K_EN, 0);
    push_exp(t0+42, K_STATE, S_FAULT); push_exp(t0+42, K_CF, 0);
    vg[2] = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      tick();
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front(); got = obs(e.kind); total++;
        if (got !== e.val) begin bad++; $display("FAIL vfilter %s cyc=%0d got=%0h exp=%0h", kname(e.kind), cyc, got, e.val); end
      end
      if (c == 15) vg[2] = 1'b1;
      if (c == 16) vg[2] = 1'b0;
      if (c == 32) vg[2] = 1'b1;
    end
  endtask

  task automatic test_clear_faults();
    exp_t e; logic [15:0] got; int t0;
    t0 = cyc;
    push_exp(t0+2, K_STATE, S_FAULT); push_exp(t0+2, K_VF, 4'b0100); push_exp(t0+2, K_FL, 1);
    push_exp(t0+3, K_STATE, S_IDLE);  push_exp(t0+3, K_VF, 0);       push_exp(t0+3, K_FL, 0);
    push_exp(t0+3, K_RC, 0);          push_exp(t0+3, K_EN, 0);
    i_clearFaults = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front(); got = obs(e.kind); total++;
        if (got !== e.val) begin bad++; $display("FAIL clear %s cyc=%0d got=%0h exp=%0h", kname(e.kind), cyc, got, e.val); end
      end
      if (c == 1) i_clearFaults = 1'b0;
      if (c == 2) begin i_enable = 1'b0; i_clearFaults = 1'b1; end
      if (c == 3) i_clearFaults = 1'b0;
    end
  endtask

  task automatic test_startup_fault();
    exp_t e; logic [15:0] got; int t0;
    t0 = cyc;
    push_exp(t0+1, K_EN, 1);
    push_exp(t0+9, K_CF, 4'b0001); push_exp(t0+9, K_VF, 0);  push_exp(t0+9, K_STATE, S_SD);
    push_exp(t0+9, K_EN, 0);       push_exp(t0+9, K_GOOD, 0); push_exp(t0+9, K_FL, 1);
    push_exp(t0+11, K_STATE, S_FAULT); push_exp(t0+11, K_CF, 4'b0001);
    push_exp(t0+13, K_STATE, S_IDLE);  push_exp(t0+13, K_CF, 0); push_exp(t0+13, K_FL, 0);
    cg[0] = 1'b0; i_enable = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front(); got = obs(e.kind); total++;
        if (got !== e.val) begin bad++; $display("FAIL startup %s cyc=%0d got=%0h exp=%0h", kname(e.kind), cyc, got, e.val); end
      end
      if (c == 8)  i_enable = 1'b0;
      if (c == 9)  i_clearFaults = 1'b1;
      if (c == 10) i_clearFaults = 1'b0;
      if (c == 11) cg = 4'hF;
      if (c == 12) i_clearFaults = 1'b1;
      if (c == 13) i_clearFaults = 1'b0;
    end
  endtask

  task automatic test_enable_drop();
    exp_t e; logic [15:0] got; int t0;
    t0 = cyc;
    push_exp(t0+25, K_STATE, S_RUN);
    push_exp(t0+27, K_STATE, S_SD); push_exp(t0+27, K_EN, 3); push_exp(t0+27, K_GOOD, 3);
    push_exp(t0+27, K_RG, 4'b0111);
    push_exp(t0+30, K_EN, 3); push_exp(t0+31, K_EN, 1); push_exp(t0+31, K_GOOD, 1);
    push_exp(t0+35, K_EN, 0);
    push_exp(t0+37, K_STATE, S_IDLE); push_exp(t0+37, K_VF, 0); push_exp(t0+37, K_CF, 0);
    push_exp(t0+37, K_FL, 0);
    i_enable = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      tick();
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front(); got = obs(e.kind); total++;
        if (got !== e.val) begin bad++; $display("FAIL endrop %s cyc=%0d got=%0h exp=%0h", kname(e.kind), cyc, got, e.val); end
      end
      if (c == 26) i_enable = 1'b0;
    end
  endtask

  task automatic test_reset_mid_ramp();
    exp_t e; logic [15:0] got; int t0;
    t0 = cyc;
    push_exp(t0+12, K_EN, 3); push_exp(t0+12, K_STATE, S_RAMP);
    push_exp(t0+13, K_EN, 0); push_exp(t0+13, K_STATE, S_IDLE); push_exp(t0+13, K_GOOD, 0);
    push_exp(t0+13, K_RG, 0);
    push_exp(t0+14, K_STATE, S_IDLE);
    i_enable = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front(); got = obs(e.kind); total++;
        if (got !== e.val) begin bad++; $display("FAIL rstramp %s cyc=%0d got=%0h exp=%0h", kname(e.kind), cyc, got, e.val); end
      end
      if (c == 12) i_reset = 1'b1;
      if (c == 13) begin i_reset = 1'b0; i_enable = 1'b0; end
    end
  endtask

  task automatic test_retry();
    exp_t e; logic [15:0] got; int t0;
    t0 = cyc;
    push_exp(t0+17, K_CF, 4'b0010); push_exp(t0+17, K_STATE, S_SD); push_exp(t0+17, K_EN, 1);
    push_exp(t0+21, K_EN, 0);
    push_exp(t0+23, K_STATE, S_FAULT);
`ifdef PWRSEQ_AUTO_RETRY_EN
    push_exp(t0+31, K_STATE, S_FAULT); push_exp(t0+31, K_RC, 0);
    push_exp(t0+32, K_STATE, S_RAMP);  push_exp(t0+32, K_RC, 1); push_exp(t0+32, K_CF, 0);
    push_exp(t0+32, K_EN, 1);
    push_exp(t0+48, K_CF, 4'b0010);
    push_exp(t0+63, K_STATE, S_RAMP);  push_exp(t0+63, K_RC, 2);
    push_exp(t0+94, K_STATE, S_RAMP);  push_exp(t0+94, K_RC, 3);
    push_exp(t0+110, K_STATE, S_SD);   push_exp(t0+110, K_CF, 4'b0010);
    push_exp(t0+140, K_STATE, S_FAULT); push_exp(t0+140, K_RC, 3); push_exp(t0+140, K_CF, 4'b0010);
`else
    push_exp(t0+60, K_STATE, S_FAULT); push_exp(t0+60, K_RC, 0); push_exp(t0+60, K_CF, 4'b0010);
    push_exp(t0+140, K_STATE, S_FAULT); push_exp(t0+140, K_EN, 0);
`endif
    push_exp(t0+141, K_STATE, S_IDLE); push_exp(t0+141, K_RC, 0); push_exp(t0+141, K_CF, 0);
    cg[1] = 1'b0; i_enable = 1'b1;
    for (int c = 1; c <= 142; c++) begin
      tick();
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front(); got = obs(e.kind); total++;
        if (got !== e.val) begin bad++; $display("FAIL retry %s cyc=%0d got=%0h exp=%0h", kname(e.kind), cyc, got, e.val); end
      end
      if (c == 140) begin i_enable = 1'b0; cg = 4'hF; i_clearFaults = 1'b1; end
      if (c == 141) i_clearFaults = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_voltage_filter();
    test_clear_faults();
    test_startup_fault();
    test_enable_drop();
    test_reset_mid_ramp();
    test_retry();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
